tage_resolve_queue: RTL and testbench

// - Exec-side counterpart of the TAGE predictor. Buffers each fetch-time prediction's metadata
//   (pc, predicted direction, provider/alternate component) in order until the branch resolves.
// - On resolution, compares outcome vs prediction and emits a one-cycle update command for the

---
 rtl/tage_resolve_queue.sv | 170 +++++++++++++++++
 tb/tb_tage_resolve_queue.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/tage_resolve_queue.sv
// tage_resolve_queue: in-order buffer of TAGE fetch-time prediction metadata.
// On each branch resolution it pops the oldest entry, compares the outcome with
// the prediction and issues a registered one-cycle table update command
// (counter train, useful inc/dec, allocation, periodic useful reset).
// A mispredict flushes every younger wrong-path entry.
module tage_resolve_queue #(
    parameter int DEPTH             = 8,
    parameter int N_COMPONENTS      = 5,
    parameter int RESET_COUNTER_LEN = 18
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push_valid,
    output logic        push_ready,
    input  logic [31:0] push_pc,
    input  logic        push_taken,
    input  logic        push_alt_taken,
    input  logic [2:0]  push_provider,
    input  logic [2:0]  push_alternate,
    input  logic        resolve_valid,
    input  logic        resolve_taken,
    output logic        upd_valid,
    output logic [31:0] upd_pc,
    output logic [2:0]  upd_provider,
    output logic        upd_taken,
    output logic        upd_useful_inc,
    output logic        upd_useful_dec,
    output logic        upd_alloc,
    output logic [2:0]  upd_alloc_index,
    output logic        useful_reset,
    output logic        mispredict,
    output logic        empty,
    output logic        resolve_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);
    localparam logic [3:0]     LAST_COMP  = 4'(N_COMPONENTS - 1);
    localparam logic [15:0]    LFSR_SEED  = 16'hACE1;

    typedef struct packed {
        logic [31:0] pc;
        logic        taken;
        logic        alt_taken;
        logic [2:0]  provider;
        logic [2:0]  alternate;
    } entry_t;

    entry_t                 mem [DEPTH];
    logic [PTR_W-1:0]       head;
    logic [PTR_W-1:0]       tail;
    logic [PTR_W:0]         count;
    logic [15:0]            lfsr;
    logic [RESET_COUNTER_LEN-1:0] reset_cnt;

    logic   full;
    logic   resolve_fire;
    logic   push_fire;
    logic   mis;
    logic   useful_ok;
    logic   alloc_ok;
    logic [2:0] alloc_idx;
    logic [3:0] prov_p1;
    logic [3:0] prov_p2;
    logic [15:0] lfsr_next;
    entry_t head_entry;

    assign full       = (count == FULL_COUNT);
    assign empty      = (count == '0);
    assign push_ready = !full;
    assign head_entry = mem[head];

    // A resolve frees the head slot in the same cycle, so a push is accepted
    // even when full as long as it is paired with a resolve.
    assign resolve_fire = resolve_valid && !empty;
    assign push_fire    = push_valid && (!full || resolve_fire);

    // Decode the popped entry into the update command fields.
    always_comb begin
        mis       = resolve_fire && (resolve_taken != head_entry.taken);
        useful_ok = resolve_fire && (head_entry.provider != 3'd0)
                    && (head_entry.taken != head_entry.alt_taken);
        prov_p1   = {1'b0, head_entry.provider} + 4'd1;
        prov_p2   = {1'b0, head_entry.provider} + 4'd2;
        alloc_ok  = mis && ({1'b0, head_entry.provider} < LAST_COMP);
        alloc_idx = (lfsr[0] && (prov_p2 <= LAST_COMP)) ? prov_p2[2:0] : prov_p1[2:0];
        lfsr_next = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
    end

    // Entry storage write port.
    // NOTE: the payload array is not reset; validity is tracked solely by
    // head/tail/count, so clearing it would only cost reset fan-out.
    always_ff @(posedge clk) begin
        if (push_fire) begin
            mem[tail] <= '{pc: push_pc, taken: push_taken, alt_taken: push_alt_taken,
                           provider: push_provider, alternate: push_alternate};
        end
    end

    // Queue pointers and occupancy; a mispredict discards everything, including a same-cycle push.
    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (mis) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (resolve_fire) head <= head + PTR_W'(1);
            if (push_fire)    tail <= tail + PTR_W'(1);
            case ({push_fire, resolve_fire})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Allocation LFSR and useful-reset period counter advance once per accepted resolve.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr      <= LFSR_SEED;
            reset_cnt <= '0;
        end else if (resolve_fire) begin
            lfsr      <= lfsr_next;
            reset_cnt <= reset_cnt + RESET_COUNTER_LEN'(1);
        end
    end

    // Sticky protocol error: resolve requested with nothing queued.
    always_ff @(posedge clk) begin
        if (rst) begin
            resolve_err <= 1'b0;
        end else if (resolve_valid && empty) begin
            resolve_err <= 1'b1;
        end
    end

    // Registered update command; pulse outputs are high for exactly one cycle per resolve.
    always_ff @(posedge clk) begin
        if (rst) begin
            upd_valid       <= 1'b0;
            upd_pc          <= '0;
            upd_provider    <= '0;
            upd_taken       <= 1'b0;
            upd_useful_inc  <= 1'b0;
            upd_useful_dec  <= 1'b0;
            upd_alloc       <= 1'b0;
            upd_alloc_index <= '0;
            useful_reset    <= 1'b0;
            mispredict      <= 1'b0;
        end else begin
            upd_valid      <= resolve_fire;
            upd_useful_inc <= useful_ok && !mis;
            upd_useful_dec <= useful_ok && mis;
            upd_alloc      <= alloc_ok;
            useful_reset   <= resolve_fire && (&reset_cnt);
            mispredict     <= mis;
            if (resolve_fire) begin
                upd_pc          <= head_entry.pc;
                upd_provider    <= head_entry.provider;
                upd_taken       <= resolve_taken;
                upd_alloc_index <= alloc_ok ? alloc_idx : 3'd0;
            end
        end
    end

endmodule

// File: tb/tb_tage_resolve_queue.sv
// tb_tage_resolve_queue: directed plus randomized stimulus against a
// queue-based behavioural model of the resolve queue.
module tb_tage_resolve_queue;

    localparam int DEPTH  = 8;
    localparam int NCOMP  = 5;
    localparam int RLEN   = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        push_valid;
    logic        push_ready;
    logic [31:0] push_pc;
    logic        push_taken;
    logic        push_alt_taken;
    logic [2:0]  push_provider;
    logic [2:0]  push_alternate;
    logic        resolve_valid;
    logic        resolve_taken;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic [2:0]  upd_provider;
    logic        upd_taken;
    logic        upd_useful_inc;
    logic        upd_useful_dec;
    logic        upd_alloc;
    logic [2:0]  upd_alloc_index;
    logic        useful_reset;
    logic        mispredict;
    logic        empty;
    logic        resolve_err;

    tage_resolve_queue #(
        .DEPTH(DEPTH), .N_COMPONENTS(NCOMP), .RESET_COUNTER_LEN(RLEN)
    ) dut (
        .clk(clk), .rst(rst),
        .push_valid(push_valid), .push_ready(push_ready), .push_pc(push_pc),
        .push_taken(push_taken), .push_alt_taken(push_alt_taken),
        .push_provider(push_provider), .push_alternate(push_alternate),
        .resolve_valid(resolve_valid), .resolve_taken(resolve_taken),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_provider(upd_provider),
        .upd_taken(upd_taken), .upd_useful_inc(upd_useful_inc),
        .upd_useful_dec(upd_useful_dec), .upd_alloc(upd_alloc),
        .upd_alloc_index(upd_alloc_index), .useful_reset(useful_reset),
        .mispredict(mispredict), .empty(empty), .resolve_err(resolve_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        t;
        logic        at;
        int          prov;
    } ent_t;

    // Reference model state
    ent_t q[$];
    int   m_lfsr;
    int   m_resolves;
    bit   m_err;
    bit   e_valid, e_taken, e_inc, e_dec, e_alloc, e_ureset, e_mis;
    logic [31:0] e_pc;
    int   e_prov, e_idx;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_lfsr = 16'hACE1;
        m_resolves = 0;
        m_err = 0;
        {e_valid, e_taken, e_inc, e_dec, e_alloc, e_ureset, e_mis} = '0;
        e_pc = 0; e_prov = 0; e_idx = 0;
    endtask

    task automatic check_outputs();
        check("upd_valid", 32'(upd_valid), 32'(e_valid));
        check("mispredict", 32'(mispredict), 32'(e_mis));
        check("useful_reset", 32'(useful_reset), 32'(e_ureset));
        check("upd_useful_inc", 32'(upd_useful_inc), 32'(e_inc));
        check("upd_useful_dec", 32'(upd_useful_dec), 32'(e_dec));
        check("upd_alloc", 32'(upd_alloc), 32'(e_alloc));
        check("empty", 32'(empty), 32'(q.size() == 0));
        check("resolve_err", 32'(resolve_err), 32'(m_err));
        if (e_valid) begin
            check("upd_pc", upd_pc, e_pc);
            check("upd_provider", 32'(upd_provider), 32'(e_prov));
            check("upd_taken", 32'(upd_taken), 32'(e_taken));
            if (e_alloc) check("upd_alloc_index", 32'(upd_alloc_index), 32'(e_idx));
        end
    endtask

    // One clock of stimulus: drive at negedge, check combinational ready,
    // advance the model, check registered outputs just after the edge.
    task automatic step(input bit pv, input logic [31:0] pc, input bit t, input bit at,
                        input int prov, input bit rv, input bit rt);
        bit rfire, pfire, mis;
        ent_t e;
        int bitv;
        @(negedge clk);
        rst = 1'b0;
        push_valid = pv; push_pc = pc; push_taken = t; push_alt_taken = at;
        push_provider = 3'(prov); push_alternate = 3'($urandom_range(0, 4));
        resolve_valid = rv; resolve_taken = rt;
        #1;
        check("push_ready", 32'(push_ready), 32'(q.size() < DEPTH));
        rfire = rv && (q.size() > 0);
        pfire = pv && ((q.size() < DEPTH) || rfire);
        if (rv && q.size() == 0) m_err = 1;
        {e_valid, e_inc, e_dec, e_alloc, e_ureset, e_mis} = '0;
        mis = 0;
        if (rfire) begin
            e = q.pop_front();
            mis = (rt != e.t);
            e_valid = 1; e_mis = mis; e_pc = e.pc; e_prov = e.prov; e_taken = rt;
            if (e.prov != 0 && e.t != e.at) begin
                e_inc = !mis; e_dec = mis;
            end
            e_alloc = mis && (e.prov < NCOMP - 1);
            e_idx = ((m_lfsr & 1) == 1 && e.prov + 2 <= NCOMP - 1) ? e.prov + 2 : e.prov + 1;
            bitv = (m_lfsr ^ (m_lfsr >> 2) ^ (m_lfsr >> 3) ^ (m_lfsr >> 5)) & 1;
            m_lfsr = (m_lfsr >> 1) | (bitv << 15);
            m_resolves++;
            e_ureset = (m_resolves % (1 << RLEN)) == 0;
            if (mis) q.delete();
        end
        if (pfire && !mis) begin
            e.pc = pc; e.t = t; e.at = at; e.prov = prov;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        push_valid = 0; resolve_valid = 0;
        @(posedge clk);
        #1;
        model_reset();
        check_outputs();
        check("push_ready_rst", 32'(push_ready), 32'd1);
        check("upd_pc_rst", upd_pc, 32'd0);
        check("upd_alloc_index_rst", 32'(upd_alloc_index), 32'd0);
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b1;
        push_valid = 0; push_pc = 0; push_taken = 0; push_alt_taken = 0;
        push_provider = 0; push_alternate = 0; resolve_valid = 0; resolve_taken = 0;
        model_reset();
        do_reset();

        // Three in-order predictions, all resolved correctly
        step(1, 32'h100, 1, 0, 1, 0, 0);
        step(1, 32'h104, 1, 1, 2, 0, 0);
        step(1, 32'h108, 0, 1, 3, 0, 0);
        step(0, 0, 0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 0, 1, 0);
        idle();

        // Fill, overflow push dropped, push+resolve while full, drain
        for (int i = 0; i < DEPTH; i++) step(1, 32'h200 + 32'(4 * i), 1, 0, i % NCOMP, 0, 0);
        step(1, 32'hDEAD, 1, 0, 1, 0, 0);
        step(1, 32'h300, 1, 0, 2, 1, 1);
        check("count_full_after_swap", 32'(q.size()), 32'(DEPTH));
        for (int i = 0; i < DEPTH; i++) step(0, 0, 0, 0, 0, 1, 1);
        idle();

        // Mispredict on provider 2 flushes the younger entries
        step(1, 32'h400, 1, 0, 2, 0, 0);
        step(1, 32'h404, 1, 0, 1, 0, 0);
        step(1, 32'h408, 0, 1, 3, 0, 0);
        step(1, 32'h40C, 1, 1, 4, 0, 0);
        step(1, 32'h410, 1, 0, 1, 1, 0);
        check("alloc_idx_range", 32'(upd_alloc_index == 3'd3 || upd_alloc_index == 3'd4), 32'd1);
        idle();

        // Provider 4 mispredict: no allocation. Provider 0: no useful update.
        step(1, 32'h500, 0, 1, 4, 0, 0);
        step(0, 0, 0, 0, 0, 1, 1);
        step(1, 32'h504, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 1);
        step(1, 32'h508, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0);

        // Resolve while empty, then reset mid-queue
        step(0, 0, 0, 0, 0, 1, 1);
        idle();
        step(1, 32'h600, 1, 0, 1, 0, 0);
        step(1, 32'h604, 0, 0, 2, 0, 0);
        do_reset();

        // Randomized traffic, mostly-correct resolutions
        for (int n = 0; n < 3000; n++) begin
            bit rt;
            int prov;
            if ($urandom_range(0, 499) == 0) do_reset();
            prov = $urandom_range(0, NCOMP - 1);
            rt = (q.size() > 0) ? (q[0].t ^ ($urandom_range(0, 9) == 0)) : 1'($urandom);
            step($urandom_range(0, 99) < 60, $urandom, 1'($urandom), 1'($urandom), prov,
                 $urandom_range(0, 99) < 50, rt);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
